// File: rtl/tick_pwm_generator_if.sv
// Configuration channel for tick_pwm_generator: one period/duty pair per
// transfer, taken when cfg_valid and cfg_ready are both high at a clk edge.
interface tick_pwm_generator_if #(
  parameter int WIDTH = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/tick_pwm_generator.sv
// PWM generator stepped by rising edges of a divided tick; new period/duty
// settings are held pending and only take effect at a period boundary.
module tick_pwm_generator #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_in,
  input  logic                 enable,
  tick_pwm_generator_if.slave  cfg,
  output logic                 pwm_out,
  output logic                 period_done,
  output logic                 busy,
  output logic                 dbg_state
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] act_period, act_duty, act_period_nxt, act_duty_nxt;
  logic [WIDTH-1:0] pend_period, pend_duty;
  logic             pend_valid;
  logic             tick_q;
  logic             step, xfer, apply, done_nxt, pwm_nxt, last_step;

  // A held-high tick counts once: only its rising edge is a step.
  assign step          = tick_in & ~tick_q;
  assign cfg.cfg_ready = ~pend_valid;
  assign xfer          = cfg.cfg_valid & ~pend_valid;
  assign last_step     = (cnt == act_period - ONE);
  assign dbg_state     = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    apply     = 1'b0;
    case (state)
      IDLE: begin
        apply = pend_valid;
        // Uses the registered act_period, so a config applied here lets RUN start next cycle.
        if (enable && act_period != '0) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (step) begin
          if (last_step) begin
            cnt_nxt  = '0;
            done_nxt = 1'b1;
            apply    = pend_valid;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
      end
    endcase

    act_period_nxt = apply ? pend_period : act_period;
    act_duty_nxt   = apply ? pend_duty   : act_duty;

    // A wrap that loads period 0 parks the generator.
    if (state == RUN && state_nxt == RUN && act_period_nxt == '0) begin
      state_nxt = IDLE;
    end

    pwm_nxt = (state_nxt == RUN) && (cnt_nxt < act_duty_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tick_q      <= 1'b0;
      act_period  <= '0;
      act_duty    <= '0;
      pend_period <= '0;
      pend_duty   <= '0;
      pend_valid  <= 1'b0;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      tick_q      <= tick_in;
      act_period  <= act_period_nxt;
      act_duty    <= act_duty_nxt;
      pwm_out     <= pwm_nxt;
      period_done <= done_nxt;
      busy        <= (state_nxt == RUN);
      // xfer needs an empty slot and apply needs a full one, so they never coincide.
      if (xfer) begin
        pend_period <= cfg.cfg_period;
        pend_duty   <= cfg.cfg_duty;
        pend_valid  <= 1'b1;
      end else if (apply) begin
        pend_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tick_pwm_generator.sv
// Directed bench for tick_pwm_generator: inputs change and outputs are
// sampled on the falling clock edge; each scenario checks its own results.
module tb_tick_pwm_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_in = 1'b0;
  logic enable = 1'b0;
  logic pwm_out, period_done, busy, dbg_state;

  int checks = 0;
  int passed = 0;

  logic [1:0] exp_q[$];
  logic [1:0] e;
  bit ok;

  tick_pwm_generator_if #(.WIDTH(8)) cfg ();

  tick_pwm_generator #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_in     (tick_in),
    .enable      (enable),
    .cfg         (cfg.slave),
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic do_step();
    @(negedge clk) tick_in = 1'b1;
    @(negedge clk) tick_in = 1'b0;
  endtask

  task automatic send_cfg(input logic [7:0] p, input logic [7:0] d, output bit got);
    got = 1'b0;
    @(negedge clk);
    cfg.cfg_valid  = 1'b1;
    cfg.cfg_period = p;
    cfg.cfg_duty   = d;
    for (int i = 0; i < 40; i++) begin
      if (cfg.cfg_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic wait_busy(input logic val, output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy === val) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic start_cfg(input logic [7:0] p, input logic [7:0] d, output bit got);
    bit a, b, c;
    @(negedge clk) enable = 1'b0;
    wait_busy(1'b0, a);
    send_cfg(p, d, b);
    @(negedge clk) enable = 1'b1;
    wait_busy(1'b1, c);
    got = a & b & c;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({pwm_out, period_done, busy, cfg.cfg_ready} !== 4'b0001)
        $display("FAIL reset_%0d: pwm,done,busy,ready=%b expected 0001", i,
                 {pwm_out, period_done, busy, cfg.cfg_ready});
      else passed++;
      tick_in = ~tick_in;
    end
    rst = 1'b0;
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pwm_out, period_done, busy, cfg.cfg_ready, dbg_state} !== 5'b00010)
      $display("FAIL idle_after_reset: pwm,done,busy,ready,state=%b expected 00010",
               {pwm_out, period_done, busy, cfg.cfg_ready, dbg_state});
    else passed++;
  endtask

  task automatic test_basic();
    int hi, dn, first_dn, last_dn;
    send_cfg(8'd5, 8'd2, ok);
    enable = 1'b1;
    wait_busy(1'b1, ok);
    checks++;
    if (!ok || pwm_out !== 1'b1) $display("FAIL basic_start: ok=%0d pwm=%b expected ok=1 pwm=1", ok, pwm_out);
    else passed++;
    exp_q = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b11};
    for (int k = 0; exp_q.size() > 0; k++) begin
      do_step();
      e = exp_q.pop_front();
      checks++;
      if ({pwm_out, period_done} !== e)
        $display("FAIL basic_step%0d: pwm,done=%b expected %b", k, {pwm_out, period_done}, e);
      else passed++;
    end
    // Ten steps spaced 10 clk apart cover exactly two 50-clk periods.
    hi = 0; dn = 0; first_dn = -1; last_dn = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) hi++;
      if (period_done === 1'b1) begin
        dn++;
        if (first_dn < 0) first_dn = i;
        last_dn = i;
      end
      tick_in = (i % 10 == 0);
    end
    tick_in = 1'b0;
    checks++;
    if (hi !== 40) $display("FAIL basic_high_clks: got %0d expected 40", hi);
    else passed++;
    checks++;
    if (dn !== 2 || last_dn - first_dn !== 50)
      $display("FAIL basic_done_spacing: pulses=%0d gap=%0d expected 2 and 50", dn, last_dn - first_dn);
    else passed++;
  endtask

  task automatic test_update();
    do_step();
    checks++;
    if ({pwm_out, period_done} !== 2'b10) $display("FAIL upd_cnt1: pwm,done=%b expected 10", {pwm_out, period_done});
    else passed++;
    send_cfg(8'd4, 8'd3, ok);
    checks++;
    if (!ok || cfg.cfg_ready !== 1'b0) $display("FAIL upd_ready_low: ok=%0d ready=%b expected 1 0", ok, cfg.cfg_ready);
    else passed++;
    exp_q = '{2'b00, 2'b00, 2'b00};
    for (int k = 0; exp_q.size() > 0; k++) begin
      do_step();
      e = exp_q.pop_front();
      checks++;
      if ({pwm_out, period_done} !== e)
        $display("FAIL upd_old_step%0d: pwm,done=%b expected %b", k, {pwm_out, period_done}, e);
      else passed++;
    end
    checks++;
    if (cfg.cfg_ready !== 1'b0) $display("FAIL upd_ready_held: ready=%b expected 0", cfg.cfg_ready);
    else passed++;
    do_step();
    checks++;
    if ({pwm_out, period_done, cfg.cfg_ready} !== 3'b111)
      $display("FAIL upd_wrap: pwm,done,ready=%b expected 111", {pwm_out, period_done, cfg.cfg_ready});
    else passed++;
    exp_q = '{2'b10, 2'b10, 2'b00, 2'b11};
    for (int k = 0; exp_q.size() > 0; k++) begin
      do_step();
      e = exp_q.pop_front();
      checks++;
      if ({pwm_out, period_done} !== e)
        $display("FAIL upd_new_step%0d: pwm,done=%b expected %b", k, {pwm_out, period_done}, e);
      else passed++;
    end
  endtask

  task automatic test_extremes();
    start_cfg(8'd5, 8'd0, ok);
    checks++;
    if (!ok || pwm_out !== 1'b0) $display("FAIL duty0_start: ok=%0d pwm=%b expected 1 0", ok, pwm_out);
    else passed++;
    exp_q = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    for (int k = 0; exp_q.size() > 0; k++) begin
      do_step();
      e = exp_q.pop_front();
      checks++;
      if ({pwm_out, period_done} !== e)
        $display("FAIL duty0_step%0d: pwm,done=%b expected %b", k, {pwm_out, period_done}, e);
      else passed++;
    end
    start_cfg(8'd5, 8'd9, ok);
    checks++;
    if (!ok || pwm_out !== 1'b1) $display("FAIL duty9_start: ok=%0d pwm=%b expected 1 1", ok, pwm_out);
    else passed++;
    exp_q = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
    for (int k = 0; exp_q.size() > 0; k++) begin
      do_step();
      e = exp_q.pop_front();
      checks++;
      if ({pwm_out, period_done, busy} !== {e, 1'b1})
        $display("FAIL duty9_step%0d: pwm,done,busy=%b expected %b1", k, {pwm_out, period_done, busy}, e);
      else passed++;
    end
    start_cfg(8'd1, 8'd1, ok);
    checks++;
    if (!ok || pwm_out !== 1'b1) $display("FAIL p1_start: ok=%0d pwm=%b expected 1 1", ok, pwm_out);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      do_step();
      checks++;
      if ({pwm_out, period_done} !== 2'b11)
        $display("FAIL p1_step%0d: pwm,done=%b expected 11", k, {pwm_out, period_done});
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (period_done !== 1'b0) $display("FAIL p1_done_pulse: done=%b expected 0", period_done);
    else passed++;
  endtask

  task automatic test_held_tick();
    int dn;
    start_cfg(8'd5, 8'd1, ok);
    checks++;
    if (!ok || pwm_out !== 1'b1) $display("FAIL held_start: ok=%0d pwm=%b expected 1 1", ok, pwm_out);
    else passed++;
    dn = 0;
    @(negedge clk) tick_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (period_done === 1'b1) dn++;
    end
    tick_in = 1'b0;
    checks++;
    if (pwm_out !== 1'b0 || dn !== 0) $display("FAIL held_one_step: pwm=%b pulses=%0d expected 0 0", pwm_out, dn);
    else passed++;
    exp_q = '{2'b00, 2'b00, 2'b00, 2'b11};
    for (int k = 0; exp_q.size() > 0; k++) begin
      do_step();
      e = exp_q.pop_front();
      checks++;
      if ({pwm_out, period_done} !== e)
        $display("FAIL held_step%0d: pwm,done=%b expected %b", k, {pwm_out, period_done}, e);
      else passed++;
    end
  endtask

  task automatic test_disable();
    start_cfg(8'd5, 8'd2, ok);
    checks++;
    if (!ok) $display("FAIL dis_start: busy never rose, got 0 expected 1");
    else passed++;
    do_step();
    do_step();
    @(negedge clk);
    enable  = 1'b0;
    tick_in = 1'b1;
    @(negedge clk);
    tick_in = 1'b0;
    checks++;
    if ({busy, pwm_out, period_done, dbg_state} !== 4'b0000)
      $display("FAIL dis_stop: busy,pwm,done,state=%b expected 0000", {busy, pwm_out, period_done, dbg_state});
    else passed++;
    @(negedge clk) enable = 1'b1;
    wait_busy(1'b1, ok);
    checks++;
    if (!ok || pwm_out !== 1'b1) $display("FAIL dis_restart: ok=%0d pwm=%b expected 1 1", ok, pwm_out);
    else passed++;
    exp_q = '{2'b10, 2'b00};
    for (int k = 0; exp_q.size() > 0; k++) begin
      do_step();
      e = exp_q.pop_front();
      checks++;
      if ({pwm_out, period_done} !== e)
        $display("FAIL dis_step%0d: pwm,done=%b expected %b", k, {pwm_out, period_done}, e);
      else passed++;
    end
  endtask

  task automatic test_reset_pending();
    int bz;
    send_cfg(8'd3, 8'd1, ok);
    checks++;
    if (!ok || cfg.cfg_ready !== 1'b0) $display("FAIL rstp_pending: ok=%0d ready=%b expected 1 0", ok, cfg.cfg_ready);
    else passed++;
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, pwm_out, cfg.cfg_ready} !== 3'b001)
      $display("FAIL rstp_cleared: busy,pwm,ready=%b expected 001", {busy, pwm_out, cfg.cfg_ready});
    else passed++;
    bz = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) bz++;
    end
    checks++;
    if (bz !== 0) $display("FAIL rstp_no_run: busy cycles=%0d expected 0", bz);
    else passed++;
    send_cfg(8'd3, 8'd1, ok);
    wait_busy(1'b1, ok);
    checks++;
    if (!ok || pwm_out !== 1'b1) $display("FAIL rstp_reload: ok=%0d pwm=%b expected 1 1", ok, pwm_out);
    else passed++;
    do_step();
    checks++;
    if ({pwm_out, period_done} !== 2'b00) $display("FAIL rstp_step: pwm,done=%b expected 00", {pwm_out, period_done});
    else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    cfg.cfg_valid  = 1'b0;
    cfg.cfg_period = '0;
    cfg.cfg_duty   = '0;
    test_reset();
    test_basic();
    test_update();
    test_extremes();
    test_held_tick();
    test_disable();
    test_reset_pending();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tick_pwm_generator.md
Name: tick_pwm_generator

Overview:
- Downstream consumer of the frequency_divider output.
- Treats the divided signal `tick_in` as a time base: each rising edge of `tick_in` is one PWM step.
- Produces a PWM waveform with programmable period and duty, counted in steps.
- Period/duty are loaded through a valid/ready config handshake and take effect only at a period boundary, so the waveform never glitches.

Parameters:
- WIDTH, 8, bit width of the period, duty and step counter.

Ports:
- clk  input  1  system clock; same clock that drives the upstream divider.
- rst  input  1  synchronous, active-high reset.
- tick_in  input  1  divider output, synchronous to clk; each rising edge is one step.
- enable  input  1  run request; low forces IDLE.
- cfg_valid  input  1  config offer.
- cfg_ready  output  1  config accept; transfer occurs when cfg_valid & cfg_ready are both high at a clk edge.
- cfg_period  input  WIDTH  period in steps; 0 means disabled.
- cfg_duty  input  WIDTH  high time in steps.
- pwm_out  output  1  registered PWM output.
- period_done  output  1  one-clk pulse on wrap of the step counter.
- busy  output  1  high while in RUN.

Behaviour:
- Clocking and reset:
  - One clock. rst is synchronous, active-high, sampled on the clk rising edge.
  - Reset values: pwm_out=0, period_done=0, busy=0, cfg_ready=1, state=IDLE, cnt=0.
  - Reset values of internal registers: tick_q=0, act_period=0, act_duty=0, pend_valid=0.
  - rst has priority over every other event, including mid-period and mid-handshake; a pending config is discarded.
- Edge detect:
  - tick_q <= tick_in every cycle.
  - step = tick_in & ~tick_q (combinational). A `tick_in` held high counts once.
- Config path:
  - cfg_ready = ~pend_valid.
  - On transfer: pend_period/pend_duty capture the inputs and pend_valid <= 1.
  - A pending config is applied (act_* <= pend_*, pend_valid <= 0) in either case:
    - (a) any cycle in IDLE;
    - (b) in RUN, on the wrap cycle.
  - If the apply happens in the same cycle as a transfer is offered, cfg_ready is still 0 that cycle, so no transfer occurs. The new transfer can occur on the next cycle.
- State machine: IDLE, RUN.
  - IDLE -> RUN when enable=1 and act_period!=0 (act_period is the post-apply value visible that cycle; a config applied in IDLE allows RUN on the following cycle). Entry sets cnt=0.
  - RUN -> IDLE on the next edge when enable=0. cnt<=0 and pwm_out<=0 on the same edge.
  - In RUN, when step=1:
    - if cnt==act_period-1: cnt<=0 and period_done<=1 (one cycle), and the pending config is applied at that edge;
    - otherwise cnt<=cnt+1.
  - In RUN, when step=0: cnt holds.
  - If a wrap applies period=0: RUN -> IDLE on that edge.
- Output rules:
  - pwm_out is registered and updated on the same edge as cnt. It equals (next_state==RUN) && (next_cnt < next_act_duty).
  - duty=0 gives a constant 0.
  - duty>=period gives a constant 1 while in RUN.
  - busy = (state==RUN), registered.
  - Width: cnt is WIDTH bits; the compare is unsigned; cnt never exceeds act_period-1, so no overflow.
  - period=1: wraps every step; period_done pulses on every step.
- Simultaneous events:
  - enable falling on a step/wrap cycle: IDLE wins, period_done=0, but a pending config is still applied (the IDLE rule takes effect next cycle).
  - step and transfer in the same cycle: both are processed; the new config waits for the next wrap.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles with tick_in toggling -> pwm_out=0, busy=0, cfg_ready=1, period_done=0 throughout.
- Basic PWM:
  - Stimulus: config period=5, duty=2 in IDLE; enable=1; tick_in rising every 10 clk.
  - Response: pwm_out high for 2 steps (20 clk), low for 3 steps (30 clk).
  - Response: period_done pulses exactly 1 clk every 50 clk.
- Glitch-free update:
  - Stimulus: while running 5/2, offer period=4, duty=3 mid-period.
  - Response: cfg_ready drops to 0 the cycle after transfer; the current period completes as 2 high / 3 low.
  - Response: the next period is 3 high / 1 low; cfg_ready returns to 1 at the wrap.
- Extremes:
  - duty=0 -> pwm_out constant 0.
  - duty=9, period=5 -> constant 1 while busy.
  - period=1, duty=1 -> period_done pulses on every step.
- tick_in held high for 30 clk -> one step only; cnt advances by 1.
- Disable and reset mid-operation:
  - enable low at step 3 of 5 -> next clk: busy=0, pwm_out=0; re-enable restarts at cnt=0.
  - rst asserted during a pending config -> pending config dropped, act_period=0, no RUN after reset until a new config is loaded.
